// File: rtl/mult_tile_accumulator.sv
// mult_tile_accumulator
// Sums NUM_TILES consecutive adder-tree result vectors element-wise. When the
// last tile arrives it streams the accumulated result out, one element per
// cycle, over a valid/ready interface. Accumulation and drain never overlap,
// so no new vector is taken while a result is being streamed out.
module mult_tile_accumulator #(
   parameter int N_ELEM    = 9,
   parameter int ACC_WIDTH = 16,
   parameter int NUM_TILES = 4,
   parameter int OUT_WIDTH = 18,
   localparam int IDX_W    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clr,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [N_ELEM-1:0][ACC_WIDTH-1:0]   mult,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [OUT_WIDTH-1:0]               out_data,
   output logic [IDX_W-1:0]                   out_idx,
   output logic                               out_last,
   output logic                               busy
);

   localparam int CNT_W = $clog2(NUM_TILES + 1);
   localparam logic [CNT_W-1:0] TILE_LAST = CNT_W'(NUM_TILES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_ELEM - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tile_cnt_q, tile_cnt_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;

   // Accumulator contents gathered into one vector for the output mux.
   logic [N_ELEM-1:0][OUT_WIDTH-1:0] acc_vec;

   logic accept;
   logic acc_load;
   logic acc_add;

   // An abort cycle never takes a vector, even though in_ready is not lowered.
   assign accept   = in_valid && in_ready && !clr;
   // First tile overwrites the accumulator, so no residue from an earlier or
   // aborted result can leak into the new one.
   assign acc_load = accept && (state_q == ST_IDLE);
   assign acc_add  = accept && (state_q == ST_ACCUM);

   // Control next-state: tile counting, drain index and state transitions.
   always_comb begin
      state_d    = state_q;
      tile_cnt_d = tile_cnt_q;
      out_idx_d  = out_idx_q;
      if (clr) begin
         state_d    = ST_IDLE;
         tile_cnt_d = '0;
         out_idx_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  tile_cnt_d = CNT_W'(1);
                  state_d    = (NUM_TILES == 1) ? ST_DRAIN : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  tile_cnt_d = tile_cnt_q + CNT_W'(1);
                  if (tile_cnt_q == TILE_LAST) begin
                     state_d = ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  if (out_idx_q == IDX_LAST) begin
                     out_idx_d  = '0;
                     tile_cnt_d = '0;
                     state_d    = ST_IDLE;
                  end else begin
                     out_idx_d = out_idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_d    = ST_IDLE;
               tile_cnt_d = '0;
               out_idx_d  = '0;
            end
         endcase
      end
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tile_cnt_q <= '0;
         out_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         tile_cnt_q <= tile_cnt_d;
         out_idx_q  <= out_idx_d;
      end
   end

   // One accumulator lane per result element.
   generate
      for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
         logic [OUT_WIDTH-1:0] mult_ext;
         logic [OUT_WIDTH-1:0] acc_q;
         logic [OUT_WIDTH-1:0] acc_d;

         // Unsigned operands: zero-extend, and let the sum wrap at OUT_WIDTH.
         assign mult_ext = OUT_WIDTH'(mult[gi]);

         // Lane update: overwrite on the first tile, add on later tiles.
         always_comb begin
            acc_d = acc_q;
            if (acc_load) begin
               acc_d = mult_ext;
            end else if (acc_add) begin
               acc_d = acc_q + mult_ext;
            end
         end

         // Lane register; an abort leaves it alone since the next load overwrites it.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc_q <= '0;
            end else begin
               acc_q <= acc_d;
            end
         end

         assign acc_vec[gi] = acc_q;
      end
   endgenerate

   // Outputs decode registered state only; nothing from in_* reaches out_*.
   assign in_ready  = (state_q != ST_DRAIN);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_DRAIN);
   assign out_idx   = out_idx_q;
   assign out_last  = out_valid && (out_idx_q == IDX_LAST);
   assign out_data  = acc_vec[out_idx_q];

endmodule

// File: tb/tb_mult_tile_accumulator.sv
// Directed bench for mult_tile_accumulator: hand-computed expected drains.
// A second instance with OUT_WIDTH=16 shares all inputs to show wraparound.
module tb_mult_tile_accumulator;

   localparam int N_ELEM    = 9;
   localparam int ACC_WIDTH = 16;
   localparam int NUM_TILES = 4;
   localparam int OUT_WIDTH = 18;
   localparam int IDX_W     = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   logic in_valid;
   logic out_ready;
   logic [N_ELEM-1:0][ACC_WIDTH-1:0] mult;

   logic                 in_ready, out_valid, out_last, busy;
   logic [OUT_WIDTH-1:0] out_data;
   logic [IDX_W-1:0]     out_idx;

   logic                 in_ready16, out_valid16, out_last16, busy16;
   logic [15:0]          out_data16;
   logic [IDX_W-1:0]     out_idx16;

   int errors = 0;
   int checks = 0;

   logic [OUT_WIDTH-1:0] expd [N_ELEM];

   always #5 clk = ~clk;

   mult_tile_accumulator #(
      .N_ELEM(N_ELEM), .ACC_WIDTH(ACC_WIDTH), .NUM_TILES(NUM_TILES), .OUT_WIDTH(OUT_WIDTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .mult(mult),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .busy(busy)
   );

   mult_tile_accumulator #(
      .N_ELEM(N_ELEM), .ACC_WIDTH(ACC_WIDTH), .NUM_TILES(NUM_TILES), .OUT_WIDTH(16)
   ) dut16 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready16), .mult(mult),
      .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
      .out_idx(out_idx16), .out_last(out_last16), .busy(busy16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N_ELEM-1:0][ACC_WIDTH-1:0] fill(input logic [ACC_WIDTH-1:0] v);
      logic [N_ELEM-1:0][ACC_WIDTH-1:0] r;
      for (int i = 0; i < N_ELEM; i++) r[i] = v;
      return r;
   endfunction

   function automatic logic [N_ELEM-1:0][ACC_WIDTH-1:0] ramp();
      logic [N_ELEM-1:0][ACC_WIDTH-1:0] r;
      for (int i = 0; i < N_ELEM; i++) r[i] = ACC_WIDTH'(i + 1);
      return r;
   endfunction

   task automatic set_exp_ramp(input int k);
      for (int i = 0; i < N_ELEM; i++) expd[i] = OUT_WIDTH'(k * (i + 1));
   endtask

   task automatic set_exp_const(input logic [OUT_WIDTH-1:0] v);
      for (int i = 0; i < N_ELEM; i++) expd[i] = v;
   endtask

   // Present one vector for n consecutive accepting edges.
   task automatic send_tiles(input logic [N_ELEM-1:0][ACC_WIDTH-1:0] v, input int n);
      in_valid = 1'b1;
      mult     = v;
      repeat (n) step();
      in_valid = 1'b0;
   endtask

   // Full-rate drain of all elements, checked against expd.
   task automatic drain_all(input string tag);
      out_ready = 1'b1;
      for (int i = 0; i < N_ELEM; i++) begin
         chk({tag, "_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_idx"},   32'(out_idx), 32'(i));
         chk({tag, "_data"},  32'(out_data), 32'(expd[i]));
         chk({tag, "_data16"}, 32'(out_data16), 32'(expd[i][15:0]));
         chk({tag, "_last"},  32'(out_last), (i == N_ELEM - 1) ? 32'd1 : 32'd0);
         $display("%s: idx=%0d data=%0h data16=%0h last=%0b", tag, out_idx, out_data, out_data16, out_last);
         step();
      end
      out_ready = 1'b0;
      chk({tag, "_end_busy"},  32'(busy), 32'd0);
      chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int hs;
      int cyc;
      logic pat [4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mult = '0;
      #12;
      // Reset state
      chk("rst_in_ready",  32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy), 32'd0);
      chk("rst_out_idx",   32'(out_idx), 32'd0);
      chk("rst_out_last",  32'(out_last), 32'd0);
      rst_n = 1'b1;
      step();

      // Test 1: four back-to-back ramp vectors, latency check
      in_valid = 1'b1;
      mult     = ramp();
      repeat (3) step();
      chk("t1_pre_valid", 32'(out_valid), 32'd0);
      chk("t1_pre_busy",  32'(busy), 32'd1);
      step();
      in_valid = 1'b0;
      chk("t1_lat_valid",    32'(out_valid), 32'd1);
      chk("t1_lat_in_ready", 32'(in_ready), 32'd0);
      set_exp_ramp(4);
      drain_all("t1");

      // Test 2: gapped input at cycles 0,3,4,9 of all 0xFFFF
      mult = fill(16'hFFFF);
      for (int c = 0; c <= 9; c++) begin
         in_valid = (c == 0 || c == 3 || c == 4 || c == 9);
         step();
         if (c == 7) chk("t2_gap_valid", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b0;
      set_exp_const(18'h3FFFC);
      drain_all("t2");

      // Test 3: backpressure 1,0,0,1 with in_valid held high during drain
      send_tiles(ramp(), 4);
      set_exp_ramp(4);
      in_valid = 1'b1;
      mult     = fill(16'h0077);
      hs  = 0;
      cyc = 0;
      while (hs < N_ELEM && cyc < 60) begin
         out_ready = pat[cyc % 4];
         chk("t3_in_ready", 32'(in_ready), 32'd0);
         chk("t3_valid",    32'(out_valid), 32'd1);
         chk("t3_idx",      32'(out_idx), 32'(hs));
         chk("t3_data",     32'(out_data), 32'(expd[hs]));
         $display("t3: cyc=%0d ready=%0b idx=%0d data=%0h", cyc, out_ready, out_idx, out_data);
         if (out_ready) hs++;
         cyc++;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("t3_handshakes", 32'(hs), 32'(N_ELEM));
      chk("t3_end_busy",   32'(busy), 32'd0);
      chk("t3_end_ready",  32'(in_ready), 32'd1);

      // Test 4: back-to-back results, second one must not carry residue
      send_tiles(fill(16'd5), 4);
      set_exp_const(18'd20);
      drain_all("t4a");
      send_tiles(fill(16'd1), 4);
      set_exp_const(18'd4);
      drain_all("t4b");

      // Test 5a: abort after two tiles; in_valid in the clr cycle not taken
      send_tiles(fill(16'd7), 2);
      clr = 1'b1; in_valid = 1'b1; mult = fill(16'd2);
      step();
      clr = 1'b0; in_valid = 1'b0;
      chk("t5_clr_busy",  32'(busy), 32'd0);
      chk("t5_clr_ready", 32'(in_ready), 32'd1);
      send_tiles(fill(16'd2), 4);
      set_exp_const(18'd8);
      drain_all("t5a");

      // Test 5b: abort during drain at index 3
      send_tiles(ramp(), 4);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      chk("t5b_idx3", 32'(out_idx), 32'd3);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t5b_valid", 32'(out_valid), 32'd0);
      chk("t5b_busy",  32'(busy), 32'd0);
      chk("t5b_idx",   32'(out_idx), 32'd0);

      // Test 6: asynchronous reset mid-drain
      send_tiles(ramp(), 4);
      out_ready = 1'b1;
      repeat (2) step();
      out_ready = 1'b0;
      chk("t6_pre_idx", 32'(out_idx), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_busy",  32'(busy), 32'd0);
      chk("t6_idx",   32'(out_idx), 32'd0);
      #3;
      rst_n = 1'b1;
      step();
      chk("t6_ready", 32'(in_ready), 32'd1);
      send_tiles(fill(16'd3), 4);
      set_exp_const(18'd12);
      drain_all("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_tile_accumulator.md
Name: mult_tile_accumulator

Overview:
- Stage directly downstream of the TLUT adder tree.
- Captures each registered multiplication-result vector (DIM_ROW1*DIM_COL2 elements) and sums NUM_TILES consecutive vectors element-wise, forming one tiled matrix-multiply result.
- Then drains the accumulated result one element per cycle over a valid/ready stream to the writeback/output buffer.

Parameters:
N_ELEM, 9, number of result elements per vector (DIM_ROW1*DIM_COL2)
ACC_WIDTH, 16, width of each incoming adder-tree element
NUM_TILES, 4, vectors accumulated per result (>=1)
OUT_WIDTH, 18, accumulator/output element width (ACC_WIDTH + clog2(NUM_TILES) for lossless)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; discard partial result, return to IDLE
in_valid  input  1  mult vector valid, aligned with mult (controller delays by adder-tree latency of 1 cycle)
in_ready  output  1  block can accept a vector this cycle
mult  input  N_ELEM*ACC_WIDTH  packed [N_ELEM-1:0][ACC_WIDTH-1:0] adder-tree results
out_valid  output  1  out_data holds a valid element
out_ready  input  1  downstream accepts element
out_data  output  OUT_WIDTH  accumulated element acc[out_idx]
out_idx  output  clog2(N_ELEM)  index of current element
out_last  output  1  high with the final element (out_idx==N_ELEM-1)
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE, acc[*]=0, tile_cnt=0, out_idx=0, out_valid=0, out_last=0, busy=0. in_ready=1 after reset (combinational from state).
- Arithmetic: unsigned. mult elements zero-extended to OUT_WIDTH. Sum wraps modulo 2^OUT_WIDTH; no saturation, no overflow flag.
- States: IDLE, ACCUM, DRAIN. in_ready=1 in IDLE/ACCUM, 0 in DRAIN. Accept = in_valid && in_ready.
- IDLE: on accept, acc[i] <= mult[i] (overwrite, not add), tile_cnt <= 1. If NUM_TILES==1 -> DRAIN, else -> ACCUM.
- ACCUM: on accept, acc[i] <= acc[i] + mult[i], tile_cnt++. The accept bringing tile_cnt to NUM_TILES -> DRAIN. No accept leaves all state unchanged (gaps allowed).
- DRAIN:
  - out_valid=1; out_data=acc[out_idx]; out_last=(out_idx==N_ELEM-1).
  - On out_valid && out_ready: out_idx++. The final handshake sets out_idx<=0, tile_cnt<=0 and state<=IDLE.
  - out_data/out_idx are stable while out_valid && !out_ready.
- Output timing: outputs are combinational decodes of registered state/acc; no comb path from in_* to out_*.
- Latency: first element valid the cycle after the NUM_TILES-th accept. Throughput: one result per NUM_TILES + N_ELEM cycles minimum (no overlap of drain and accumulate).
- clr:
  - Highest priority. Next state IDLE, tile_cnt=0, out_idx=0.
  - acc is not cleared; it is overwritten by the next IDLE accept.
  - An in_valid in the clr cycle is not accepted, although in_ready is not forced low.
  - clr in DRAIN drops out_valid next cycle.
- in_valid in DRAIN is ignored (in_ready=0). Upstream must hold.
- Reset mid-ACCUM or mid-DRAIN: immediate return to reset values; partial result is lost.

Test Plan:
- NUM_TILES=4, four back-to-back vectors with all elements = i+1 (element i) -> drain emits 4,8,...,36 at idx 0..8; out_last only at idx 8; first out_valid 1 cycle after 4th accept.
- Gapped input: vectors at cycles 0,3,4,9 with mult=all 0xFFFF, OUT_WIDTH=18 -> each element 0x3FFFC. With OUT_WIDTH=16 -> wraps to 0xFFFC.
- Backpressure: out_ready toggling 1,0,0,1 during drain -> each element held stable while stalled; in_ready=0 throughout drain; exactly 9 handshakes, then IDLE.
- Two results back-to-back: second result accumulates from overwrite, not residual -> second drain values independent of first (e.g. first all 5s, second all 1s -> 4 each).
- clr asserted after 2 of 4 tiles, then 4 fresh tiles of all 2s -> output 8 each, not 8 plus residue; clr during drain at idx 3 -> out_valid low next cycle, busy=0.
- rst_n pulsed low mid-DRAIN (asynchronous, between edges) -> out_valid, busy, out_idx immediately 0; after release in_ready=1 and a new 4-tile sequence drains correctly.
